// File: rtl/ifetch_unit.sv
// ifetch_unit -- instruction fetch front end.
//
// Issues sequential 16-bit fetches toward instruction memory, keeps at most
// DEPTH words either queued or in flight, and hands them to decode in program
// order together with their byte address. A redirect flushes the queue and
// turns every request still in flight into one that is silently dropped when
// its response returns.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   mem_req/mem_addr/mem_ready fetch request channel toward memory
//   mem_rsp_valid/mem_rsp_data in-order responses from memory
//   inst_valid/inst/inst_pc    queue head toward decode
//   inst_ready                 decode consumes the head
//   redirect/redirect_addr     flush and restart fetch at a new address
//   halt                       stop issuing new fetches
//   busy                       a request is still outstanding
module ifetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rsp_valid,
    input  logic [15:0] mem_rsp_data,
    output logic        inst_valid,
    output logic [15:0] inst,
    output logic [15:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_addr,
    input  logic        halt,
    output logic        busy
);

    localparam int CW  = $clog2(DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0]   DEPTH_C = CW1'(DEPTH);
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

    logic [15:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] occ;
    logic [PW-1:0] iq_wr, iq_rd;
    logic [PW-1:0] fl_wr, fl_rd;

    logic [15:0] iq_inst [DEPTH];
    logic [15:0] iq_pc   [DEPTH];
    logic [15:0] fl_pc   [DEPTH];

    logic        accept;
    logic        rsp_keep;
    logic        pop;
    logic        has_head;
    logic [CW:0] credit;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // Queued words plus in-flight requests may never exceed DEPTH, so a
    // response always finds a free queue slot.
    assign credit   = {1'b0, occ} + {1'b0, outstanding};
    // rst_n gates the request so it drops the moment reset is applied.
    assign mem_req  = rst_n && !halt && !redirect && (credit < DEPTH_C);
    assign mem_addr = fetch_pc;
    assign accept   = mem_req && mem_ready;

    // A response is kept only when no older redirect has condemned it and no
    // redirect is flushing the queue in this same cycle.
    assign rsp_keep = mem_rsp_valid && !redirect && (discard == '0);

    assign has_head   = (occ != '0);
    assign inst_valid = has_head && !redirect;
    assign pop        = inst_valid && inst_ready;
    assign inst       = has_head ? iq_inst[iq_rd] : 16'h0000;
    assign inst_pc    = has_head ? iq_pc[iq_rd]   : 16'h0000;
    assign busy       = (outstanding != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            occ         <= '0;
            iq_wr       <= '0;
            iq_rd       <= '0;
            fl_wr       <= '0;
            fl_rd       <= '0;
        end else begin
            // accept and redirect are mutually exclusive (mem_req masks it).
            if (redirect) begin
                fetch_pc <= redirect_addr & 16'hFFFE;
            end else if (accept) begin
                fetch_pc <= fetch_pc + 16'd2;
            end
            if (accept)        fl_wr <= ptr_inc(fl_wr);
            // Every response, kept or dropped, retires its in-flight PC.
            if (mem_rsp_valid) fl_rd <= ptr_inc(fl_rd);

            outstanding <= outstanding + CW'(accept) - CW'(mem_rsp_valid);

            if (redirect) begin
                // Everything still in flight after this cycle is stale.
                discard <= outstanding - CW'(mem_rsp_valid);
                occ     <= '0;
                iq_wr   <= '0;
                iq_rd   <= '0;
            end else begin
                if (mem_rsp_valid && (discard != '0)) discard <= discard - CW'(1);
                if (rsp_keep) iq_wr <= ptr_inc(iq_wr);
                if (pop)      iq_rd <= ptr_inc(iq_rd);
                occ <= occ + CW'(rsp_keep) - CW'(pop);
            end
        end
    end

    // Storage needs no reset: the pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (accept) fl_pc[fl_wr] <= fetch_pc;
        if (rsp_keep) begin
            iq_inst[iq_wr] <= mem_rsp_data;
            iq_pc[iq_wr]   <= fl_pc[fl_rd];
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Testbench for ifetch_unit: a memory model with random in-order latency,
// a program-order scoreboard of expected {pc, inst} pairs, directed
// scenarios followed by a randomized phase, plus a second instance that
// starts near the top of the address space to exercise wrap-around.
module tb_ifetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [15:0] RPC   = 16'h0000;

    logic        clk, rst_n;
    logic        mem_req, mem_ready, mem_rsp_valid;
    logic [15:0] mem_addr, mem_rsp_data;
    logic        inst_valid, inst_ready, redirect, halt, busy;
    logic [15:0] inst, inst_pc, redirect_addr;

    logic        w_req, w_rsp_valid, w_inst_valid, w_busy;
    logic        w_one, w_zero;
    logic [15:0] w_addr, w_rsp_data, w_inst, w_inst_pc, w_zero16;

    ifetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .redirect(redirect),
        .redirect_addr(redirect_addr), .halt(halt), .busy(busy)
    );

    ifetch_unit #(.RESET_PC(16'hFFFC), .DEPTH(DEPTH)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .mem_req(w_req), .mem_addr(w_addr), .mem_ready(w_one),
        .mem_rsp_valid(w_rsp_valid), .mem_rsp_data(w_rsp_data),
        .inst_valid(w_inst_valid), .inst(w_inst), .inst_pc(w_inst_pc),
        .inst_ready(w_one), .redirect(w_zero),
        .redirect_addr(w_zero16), .halt(w_zero), .busy(w_busy)
    );

    assign w_one    = 1'b1;
    assign w_zero   = 1'b0;
    assign w_zero16 = 16'h0000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents: an arbitrary but fixed function of the address.
    function automatic logic [15:0] word_at(input logic [15:0] a);
        return {a[6:0], a[15:7]} ^ 16'h9C35;
    endfunction

    typedef struct { logic [15:0] addr; int due; bit stale; } pend_t;
    typedef struct { logic [15:0] pc; logic [15:0] data; } exp_t;

    pend_t pend_q[$];
    exp_t  exp_q[$];

    int          n_tests, n_fail;
    int          cyc, deliv_cnt, acc_cnt;
    logic [15:0] exp_fetch, last_pc;
    bit          popped_now, rel_pending, just_rel;
    int          p_mr, p_ir, p_rd, p_h, lat_lo, lat_hi;
    bit          rd_force;
    logic [15:0] rd_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every instruction decode consumes must be the next expected one.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (rst_n && inst_valid && inst_ready) begin
                popped_now = 1'b1;
                deliv_cnt++;
                last_pc = inst_pc;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL deliver: got pc %0h expected nothing (cycle %0d)", inst_pc, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("deliver_pc", inst_pc, e.pc);
                    chk("deliver_inst", inst, e.data);
                end
            end
        end
    end

    // One clock cycle: drive inputs after the edge, observe before the next.
    task automatic tick();
        int stale;
        bit acc;
        @(posedge clk);
        #1;
        just_rel = rel_pending;
        if (rel_pending) begin
            rst_n = 1'b1;
            rel_pending = 1'b0;
        end
        cyc++;
        mem_ready  = (int'($urandom_range(99)) < p_mr);
        inst_ready = (int'($urandom_range(99)) < p_ir);
        halt       = (int'($urandom_range(99)) < p_h);
        if (rd_force) begin
            redirect      = 1'b1;
            redirect_addr = rd_addr;
            rd_force      = 1'b0;
        end else begin
            redirect      = (int'($urandom_range(99)) < p_rd);
            redirect_addr = ($urandom_range(3) == 0) ? 16'(16'hFFF0 + $urandom_range(15))
                                                     : 16'($urandom);
        end
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 16'($urandom);
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = word_at(pend_q[0].addr);
        end

        @(negedge clk);
        #1;
        stale = 0;
        foreach (pend_q[i]) if (pend_q[i].stale) stale++;
        if (just_rel) chk("req_after_reset", 32'(mem_req), 32'(!halt));
        chk("busy", 32'(busy), 32'(pend_q.size() != 0));
        chk("mem_req", 32'(mem_req),
            32'(!halt && !redirect && (exp_q.size() + int'(popped_now) + stale < DEPTH)));
        if (redirect) chk("valid_during_redirect", 32'(inst_valid), 0);
        acc = mem_req && mem_ready;
        if (mem_rsp_valid) void'(pend_q.pop_front());
        if (acc) begin
            chk("mem_addr", mem_addr, exp_fetch);
            pend_q.push_back('{addr: mem_addr, due: cyc + int'($urandom_range(lat_hi, lat_lo)), stale: 1'b0});
            exp_q.push_back('{pc: exp_fetch, data: word_at(exp_fetch)});
            exp_fetch = exp_fetch + 16'd2;
            acc_cnt++;
        end
        if (redirect) begin
            foreach (pend_q[i]) pend_q[i].stale = 1'b1;
            exp_q.delete();
            exp_fetch = redirect_addr & 16'hFFFE;
        end
        popped_now = 1'b0;
    endtask

    // Asynchronous reset applied between clock edges; memory forgets everything.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_inst_valid", 32'(inst_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
        pend_q.delete();
        exp_q.delete();
        exp_fetch     = RPC;
        mem_rsp_valid = 1'b0;
        redirect      = 1'b0;
        popped_now    = 1'b0;
        repeat (2) @(posedge clk);
        rel_pending = 1'b1;
    endtask

    // Wrap instance: latency-1 memory, always ready, records first three PCs.
    logic        w_acc;
    logic [15:0] w_acc_addr;
    logic [15:0] w_pc [3];
    logic [15:0] w_dat [3];
    int          w_cnt;

    initial begin
        w_rsp_valid = 1'b0;
        w_rsp_data  = 16'h0000;
        w_acc       = 1'b0;
        w_acc_addr  = 16'h0000;
        w_cnt       = 0;
        forever begin
            @(negedge clk);
            w_acc      = rst_n && w_req;
            w_acc_addr = w_addr;
            if (rst_n && w_inst_valid && w_cnt < 3) begin
                w_pc[w_cnt]  = w_inst_pc;
                w_dat[w_cnt] = w_inst;
                w_cnt++;
            end
            @(posedge clk);
            #1;
            w_rsp_valid = w_acc && rst_n;
            w_rsp_data  = word_at(w_acc_addr);
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0, a0, k;
        rst_n = 1'b0;
        mem_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 16'h0000;
        inst_ready = 1'b0; redirect = 1'b0; redirect_addr = 16'h0000; halt = 1'b0;
        n_tests = 0; n_fail = 0; cyc = 0; deliv_cnt = 0; acc_cnt = 0;
        exp_fetch = RPC; last_pc = 16'h0000;
        popped_now = 1'b0; rel_pending = 1'b0; just_rel = 1'b0; rd_force = 1'b0; rd_addr = 16'h0000;
        p_mr = 100; p_ir = 100; p_rd = 0; p_h = 0; lat_lo = 1; lat_hi = 1;

        // Streaming: one instruction per cycle after two cycles of startup.
        do_reset();
        d0 = deliv_cnt;
        repeat (20) tick();
        chk("stream_rate", deliv_cnt - d0, 18);

        // Backpressure: credit stops fetch after DEPTH requests.
        do_reset();
        p_ir = 0;
        a0 = acc_cnt;
        repeat (12) tick();
        chk("bp_req_count", acc_cnt - a0, 4);
        chk("bp_req_low", 32'(mem_req), 0);
        chk("bp_head_pc", inst_pc, RPC);
        p_ir = 100;
        d0 = deliv_cnt;
        repeat (8) tick();
        chk("bp_drain", 32'(deliv_cnt - d0 >= 4), 1);

        // Redirect with three outstanding at latency 3, halted so busy can fall.
        do_reset();
        lat_lo = 3; lat_hi = 3;
        d0 = deliv_cnt;
        repeat (3) tick();
        rd_force = 1'b1; rd_addr = 16'h0040; p_h = 100;
        tick();
        k = 0;
        while (busy && k < 20) begin tick(); k++; end
        chk("redir_busy_fall", 32'(busy), 0);
        chk("redir_dropped", deliv_cnt - d0, 0);
        p_h = 0;
        k = 0;
        while (deliv_cnt == d0 && k < 20) begin tick(); k++; end
        chk("redir_next_pc", last_pc, 16'h0040);

        // Halt with two outstanding: both delivered, nothing new issued.
        do_reset();
        repeat (2) tick();
        p_h = 100;
        d0 = deliv_cnt; a0 = acc_cnt;
        repeat (8) tick();
        chk("halt_delivered", deliv_cnt - d0, 2);
        chk("halt_no_issue", acc_cnt - a0, 0);
        chk("halt_busy", 32'(busy), 0);
        p_h = 0;

        // Reset with a part-full queue and requests still in flight.
        do_reset();
        p_ir = 0;
        repeat (5) tick();
        do_reset();
        p_ir = 100;
        tick();
        chk("rst_refetch_addr", mem_addr, RPC);

        // Randomized traffic with occasional resets.
        lat_lo = 1; lat_hi = 4; p_mr = 70; p_ir = 60; p_rd = 4; p_h = 10;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (i % 1000 == 999) do_reset();
        end

        // Drain and confirm nothing expected is left behind.
        p_rd = 0; p_h = 100; p_ir = 100; p_mr = 100;
        k = 0;
        while ((busy || inst_valid) && k < 60) begin tick(); k++; end
        chk("drain_idle", 32'(busy || inst_valid), 0);
        chk("drain_scoreboard", exp_q.size(), 0);

        chk("wrap_count", w_cnt, 3);
        chk("wrap_pc0", w_pc[0], 16'hFFFC);
        chk("wrap_pc1", w_pc[1], 16'hFFFE);
        chk("wrap_pc2", w_pc[2], 16'h0000);
        chk("wrap_inst2", w_dat[2], word_at(16'h0000));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
